// File: rtl/weight_fetch_ctrl.sv
// rtl/weight_fetch_ctrl.sv - weight BRAM to preload-array kernel sequencer
// Streams num_kernels 5x5 binary kernels, one 5-bit column per cycle, with an ack between kernels.
module weight_fetch_ctrl #(
   parameter int ADDR_W   = 10,
   parameter int BRAM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] kernel_base,
   input  logic [7:0]        num_kernels,
   input  logic              kernel_ack,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [4:0]        bram_dout,
   output logic [4:0]        weight_from_bram,
   output logic              input_valid,
   output logic              kernel_done,
   output logic              all_done,
   output logic              busy
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ISSUE    = 2'd1;
   localparam logic [1:0] S_DRAIN    = 2'd2;
   localparam logic [1:0] S_WAIT_ACK = 2'd3;

   logic [1:0]          state;
   logic [2:0]          col;
   logic [7:0]          k;
   logic [7:0]          num_lat;
   logic [ADDR_W-1:0]   kaddr;
   logic [BRAM_LAT-1:0] rd_pipe;
   logic [2:0]          ret_cnt;
   logic                rd_ret;
   logic                last_kernel;
   logic                drain_done;

   // kaddr tracks base + 5*k incrementally so no multiplier is needed
   assign rd_ret      = rd_pipe[BRAM_LAT-1];
   assign bram_en     = (state == S_ISSUE);
   assign bram_addr   = bram_en ? (kaddr + ADDR_W'(col)) : '0;
   assign busy        = (state != S_IDLE);
   assign last_kernel = (k == (num_lat - 8'd1));
   assign drain_done  = (rd_pipe == '0) && input_valid && (ret_cnt == 3'd5);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pipe          <= '0;
         weight_from_bram <= '0;
         input_valid      <= 1'b0;
      end else begin
         rd_pipe[0] <= bram_en;
         for (int i = 1; i < BRAM_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
         input_valid <= rd_ret;
         if (rd_ret) begin
            weight_from_bram <= bram_dout;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         col         <= '0;
         k           <= '0;
         num_lat     <= '0;
         kaddr       <= '0;
         ret_cnt     <= '0;
         kernel_done <= 1'b0;
         all_done    <= 1'b0;
      end else begin
         kernel_done <= 1'b0;
         all_done    <= 1'b0;
         if (rd_ret) begin
            ret_cnt <= ret_cnt + 3'd1;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (num_kernels == 8'd0) begin
                     all_done <= 1'b1;
                  end else begin
                     num_lat <= num_kernels;
                     kaddr   <= kernel_base;
                     k       <= '0;
                     col     <= '0;
                     ret_cnt <= '0;
                     state   <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               col <= col + 3'd1;
               if (col == 3'd4) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drain_done) begin
                  kernel_done <= 1'b1;
                  state       <= S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (kernel_ack) begin
                  if (last_kernel) begin
                     all_done <= 1'b1;
                     state    <= S_IDLE;
                  end else begin
                     k       <= k + 8'd1;
                     kaddr   <= kaddr + ADDR_W'(5);
                     col     <= '0;
                     ret_cnt <= '0;
                     state   <= S_ISSUE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb/tb_weight_fetch_ctrl.sv - self-checking bench for weight_fetch_ctrl
// Table scenarios, random scenarios against an event-level model, and hand sequences for reset and latency.
module tb_weight_fetch_ctrl;

   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          start = 1'b0, kernel_ack = 1'b0;
   logic [AW-1:0] kernel_base = '0;
   logic [7:0]    num_kernels = '0;
   logic          bram_en, input_valid, kernel_done, all_done, busy;
   logic [AW-1:0] bram_addr;
   logic [4:0]    bram_dout, weight_from_bram;

   logic          start_3 = 1'b0, kernel_ack_3 = 1'b0;
   logic [AW-1:0] kernel_base_3 = '0;
   logic [7:0]    num_kernels_3 = '0;
   logic          bram_en_3, input_valid_3, kernel_done_3, all_done_3, busy_3;
   logic [AW-1:0] bram_addr_3;
   logic [4:0]    bram_dout_3, weight_from_bram_3;

   weight_fetch_ctrl #(.ADDR_W(AW), .BRAM_LAT(1)) dut (
      .clk(clk), .rst(rst), .start(start), .kernel_base(kernel_base),
      .num_kernels(num_kernels), .kernel_ack(kernel_ack), .bram_en(bram_en),
      .bram_addr(bram_addr), .bram_dout(bram_dout), .weight_from_bram(weight_from_bram),
      .input_valid(input_valid), .kernel_done(kernel_done), .all_done(all_done), .busy(busy)
   );

   weight_fetch_ctrl #(.ADDR_W(AW), .BRAM_LAT(3)) dut_3 (
      .clk(clk), .rst(rst), .start(start_3), .kernel_base(kernel_base_3),
      .num_kernels(num_kernels_3), .kernel_ack(kernel_ack_3), .bram_en(bram_en_3),
      .bram_addr(bram_addr_3), .bram_dout(bram_dout_3), .weight_from_bram(weight_from_bram_3),
      .input_valid(input_valid_3), .kernel_done(kernel_done_3), .all_done(all_done_3), .busy(busy_3)
   );

   logic [4:0] mem [1024];
   logic [4:0] d3_a, d3_b;

   always @(posedge clk) bram_dout <= mem[bram_addr];
   always @(posedge clk) begin
      d3_a        <= mem[bram_addr_3];
      d3_b        <= d3_a;
      bram_dout_3 <= d3_b;
   end

   typedef struct { int cyc; int val; } ev_t;
   ev_t q_addr[$];
   ev_t q_w[$];
   int  q_kd[$];
   int  q_ad[$];
   bit  mon_en = 1'b0;

   always @(negedge clk) begin
      ev_t e;
      if (mon_en) begin
         if (bram_en) begin
            e.cyc = cyc; e.val = int'(bram_addr); q_addr.push_back(e);
         end
         if (input_valid) begin
            e.cyc = cyc; e.val = int'(weight_from_bram); q_w.push_back(e);
         end
         if (kernel_done) q_kd.push_back(cyc);
         if (all_done) q_ad.push_back(cyc);
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " bram_en"}, int'(bram_en), 0);
      chk({tag, " bram_addr"}, int'(bram_addr), 0);
      chk({tag, " weight"}, int'(weight_from_bram), 0);
      chk({tag, " input_valid"}, int'(input_valid), 0);
      chk({tag, " kernel_done"}, int'(kernel_done), 0);
      chk({tag, " all_done"}, int'(all_done), 0);
      chk({tag, " busy"}, int'(busy), 0);
   endtask

   // Drives one multi-kernel run, then checks the recorded events against
   // the timing rules: issue at S..S+4, data at S+2..S+6, done at S+7.
   task automatic run_scn(input string tag, input int base, input int num, input int dly,
                          input bit noise, input int exp_iv, input int exp_kd_lat);
      int t0, s, got, ei, a;
      int ack_at[$];
      q_addr.delete(); q_w.delete(); q_kd.delete(); q_ad.delete();
      @(negedge clk);
      mon_en = 1'b1;
      t0 = cyc;
      kernel_base = AW'(base);
      num_kernels = 8'(num);
      start = 1'b1;
      for (int k = 0; k < num; k++) begin
         got = 0;
         for (int n = 0; n < 40 && got == 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            kernel_ack = 1'b0;
            if (kernel_done) got = 1;
            else if (noise) begin
               kernel_ack = 1'b1;
               start = 1'($urandom_range(0, 1));
            end
         end
         if (got == 0) begin
            chk({tag, " kd_timeout"}, 0, 1);
            break;
         end
         chk({tag, " busy_at_kd"}, int'(busy), 1);
         repeat (dly) @(negedge clk);
         kernel_ack = 1'b1;
         ack_at.push_back(cyc);
      end
      @(negedge clk);
      start = 1'b0;
      kernel_ack = 1'b0;
      if (ack_at.size() == num) begin
         chk({tag, " all_done_after_ack"}, int'(all_done), 1);
         chk({tag, " busy_after_last_ack"}, int'(busy), 0);
      end
      repeat (12) @(negedge clk);
      mon_en = 1'b0;

      chk({tag, " n_addr"}, q_addr.size(), 5 * num);
      chk({tag, " n_input_valid"}, q_w.size(), exp_iv);
      chk({tag, " n_kernel_done"}, q_kd.size(), num);
      chk({tag, " n_all_done"}, q_ad.size(), 1);
      if (q_kd.size() > 0) chk({tag, " kd_latency"}, q_kd[0] - t0, exp_kd_lat);
      for (int k = 0; k < num && k <= ack_at.size(); k++) begin
         s = (k == 0) ? t0 + 1 : ack_at[k-1] + 1;
         if (k < q_kd.size()) chk({tag, " kd_cycle"}, q_kd[k], s + 7);
         for (int c = 0; c < 5; c++) begin
            ei = 5 * k + c;
            a  = (base + ei) % 1024;
            if (ei < q_addr.size()) begin
               chk({tag, " addr_cycle"}, q_addr[ei].cyc, s + c);
               chk({tag, " addr"}, q_addr[ei].val, a);
            end
            if (ei < q_w.size()) begin
               chk({tag, " iv_cycle"}, q_w[ei].cyc, s + c + 2);
               chk({tag, " weight"}, q_w[ei].val, int'(mem[a]));
            end
         end
      end
      if (q_ad.size() > 0 && ack_at.size() == num)
         chk({tag, " all_done_cycle"}, q_ad[0], ack_at[num-1] + 1);
   endtask

   typedef struct {
      int base; int num; int dly; bit noise;
      int exp_iv; int exp_kd_lat;
   } vec_t;
   vec_t tbl[4];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      tbl[0] = '{base: 'h010, num: 1, dly: 0, noise: 1'b0, exp_iv: 5,  exp_kd_lat: 8};
      tbl[1] = '{base: 'h3F8, num: 3, dly: 3, noise: 1'b0, exp_iv: 15, exp_kd_lat: 8};
      tbl[2] = '{base: 'h155, num: 2, dly: 1, noise: 1'b1, exp_iv: 10, exp_kd_lat: 8};
      tbl[3] = '{base: 'h3FF, num: 2, dly: 0, noise: 1'b1, exp_iv: 10, exp_kd_lat: 8};
      for (int n = 0; n < 1024; n++) mem[n] = 5'(n);

      #2 rst = 1'b1;
      #1 chk_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // BRAM_LAT=3 single kernel
      @(negedge clk);
      t0 = cyc;
      kernel_base_3 = 10'h010;
      num_kernels_3 = 8'd1;
      start_3 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start_3 = 1'b0;
         chk("lat3 cycle", cyc - t0, c);
         chk("lat3 bram_en", int'(bram_en_3), int'(c >= 1 && c <= 5));
         if (c >= 1 && c <= 5) chk("lat3 addr", int'(bram_addr_3), 'h10 + c - 1);
         chk("lat3 input_valid", int'(input_valid_3), int'(c >= 5 && c <= 9));
         if (c >= 5 && c <= 9) chk("lat3 weight", int'(weight_from_bram_3), 'h10 + c - 5);
         chk("lat3 kernel_done", int'(kernel_done_3), int'(c == 10));
         chk("lat3 all_done", int'(all_done_3), int'(c == 11));
         chk("lat3 busy", int'(busy_3), int'(c <= 10));
         kernel_ack_3 = (c == 10);
      end

      for (int i = 0; i < 4; i++)
         run_scn($sformatf("tbl%0d", i), tbl[i].base, tbl[i].num, tbl[i].dly,
                 tbl[i].noise, tbl[i].exp_iv, tbl[i].exp_kd_lat);

      // reset mid-burst, then a zero-kernel request
      @(negedge clk);
      t0 = cyc;
      kernel_base = 10'h010;
      num_kernels = 8'd1;
      start = 1'b1;
      repeat (5) @(negedge clk);
      start = 1'b0;
      chk("midrst pre bram_en", int'(bram_en), 1);
      chk("midrst pre input_valid", int'(input_valid), 1);
      #1 rst = 1'b1;
      #1 chk_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("postrst bram_en", int'(bram_en), 0);
         chk("postrst input_valid", int'(input_valid), 0);
         chk("postrst busy", int'(busy), 0);
      end
      num_kernels = 8'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero all_done", int'(all_done), 1);
      chk("zero bram_en", int'(bram_en), 0);
      chk("zero busy", int'(busy), 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("zero after all_done", int'(all_done), 0);
         chk("zero after bram_en", int'(bram_en), 0);
      end

      for (int n = 0; n < 1024; n++) mem[n] = 5'($urandom);
      for (int i = 0; i < 6; i++) begin
         int nk;
         nk = $urandom_range(1, 4);
         run_scn($sformatf("rnd%0d", i), $urandom_range(0, 1023), nk,
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), 5 * nk, 8);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Sequencer that reads one 5x5 binary kernel from weight BRAM and streams it, one 5-bit column per cycle, into the weight preload shift array. It sits directly upstream of the preload stage and drives its `weight_from_bram` and `input_valid` inputs. It loads `num_kernels` consecutive kernels and waits for a downstream acknowledge between kernels. It issues BRAM reads, absorbs the fixed BRAM read latency, and signals when the preload array holds a complete kernel.

## Interface
- `ADDR_W`, 10, BRAM word-address width
- `BRAM_LAT`, 1, BRAM read latency in cycles, legal range 1..4
- `clk` input 1 system clock, rising edge
- `rst` input 1 reset, asynchronous, active-high
- `start` input 1 single-cycle request, sampled only in IDLE
- `kernel_base` input ADDR_W address of column 0 of kernel 0, latched on accepted start
- `num_kernels` input 8 number of kernels to load, latched on accepted start
- `kernel_ack` input 1 downstream finished with the current kernel, sampled only in WAIT_ACK
- `bram_en` output 1 BRAM read enable
- `bram_addr` output ADDR_W BRAM read address
- `bram_dout` input 5 BRAM read data; bit i is kernel row i
- `weight_from_bram` output 5 registered column data to the preload stage
- `input_valid` output 1 shift enable to the preload stage
- `kernel_done` output 1 one-cycle pulse: the preload array holds the full kernel
- `all_done` output 1 one-cycle pulse: the sequence is complete
- `busy` output 1 high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, WAIT_ACK.
- **IDLE**
  - On `start` with `num_kernels` ≥ 1: latch `kernel_base` and `num_kernels`, clear the column counter `col` and kernel counter `k`, then go to ISSUE.
  - On `start` with `num_kernels` = 0: no BRAM access; pulse `all_done` the next cycle and stay in IDLE.
- **ISSUE** (5 cycles)
  - `bram_en`=1, `bram_addr` = `kernel_base` + 5·`k` + `col`, computed modulo 2^ADDR_W (wrap-around is legal).
  - `col` counts 0..4. After `col`=4, go to DRAIN.
- **Read-data path**
  - A BRAM_LAT-deep valid delay line tracks issued reads.
  - When a read returns, `weight_from_bram` <= `bram_dout` and `input_valid` <= 1, both registered. Otherwise `input_valid` <= 0 and `weight_from_bram` holds its value.
- **DRAIN**
  - Wait until the delay line is empty and the 5th `input_valid` has been presented.
  - Then pulse `kernel_done` and go to WAIT_ACK.
- **WAIT_ACK**
  - `kernel_ack` is sampled from the `kernel_done` cycle onward, so an ack in the same cycle as `kernel_done` is accepted.
  - On ack with `k` < `num_kernels`−1: `k`++, `col`=0, go to ISSUE.
  - On ack with `k` = `num_kernels`−1: go to IDLE and pulse `all_done`.
- **Column order**: column 0 is sent first. After 5 shifts, column c sits in preload position 4−c.
- **Ignored inputs**: `start` outside IDLE, and `kernel_ack` outside WAIT_ACK.
- **Reset** (any time, including mid-kernel): state=IDLE, counters=0, delay line cleared. All outputs are 0: `bram_en`, `bram_addr`, `weight_from_bram`, `input_valid`, `kernel_done`, `all_done`, `busy`. A partial kernel is discarded; reads in flight are dropped.

## Timing
- The figures below use BRAM_LAT=1 and `start` accepted at cycle T.
- `busy` is high from T+1.
- `bram_en` is high on T+1..T+5 with addresses base..base+4.
- `bram_dout` is valid on T+2..T+6.
- `input_valid` is high on T+3..T+7, carrying columns 0..4.
- `kernel_done` pulses at T+8.
- Each extra BRAM_LAT cycle shifts `input_valid` and `kernel_done` later by one.
- An ack at cycle A in WAIT_ACK produces `bram_en` at A+1 for the next kernel.
- An ack for the last kernel at cycle A produces `all_done`=1 and `busy`=0 at A+1.
- Minimum kernel-to-kernel period is 8 cycles (ack in the `kernel_done` cycle).
- `input_valid` is never high outside a 5-cycle burst per kernel, and a burst is never interrupted.

## Test plan
- **Reset values**: assert `rst` asynchronously between edges -> all outputs read 0 immediately; `busy`=0.
- **Single kernel**: `kernel_base`=0x010, `num_kernels`=1, BRAM word n = n[4:0], `start` at T -> addresses 0x010..0x014 on T+1..T+5; `weight_from_bram` = 0x10..0x14 with `input_valid` on T+3..T+7; `kernel_done` at T+8; ack at T+8 -> `all_done` at T+9.
- **Three kernels with delayed acks**: base=0x3F8, ADDR_W=10, `num_kernels`=3, ack 3 cycles after each `kernel_done` -> kernel 2 reads 0x002..0x006 (address wrap); exactly 15 `input_valid` cycles; exactly one `all_done`.
- **Ignored inputs**: `start` pulsed during ISSUE, `kernel_ack` held high during ISSUE/DRAIN -> no restart, no early next kernel, address sequence unchanged.
- **BRAM_LAT=3**: same stimulus as the single-kernel case -> `input_valid` on T+5..T+9, `kernel_done` at T+10, data is still 0x10..0x14 in order.
- **Reset mid-burst / zero kernels**: `rst` at T+5 -> outputs 0 and IDLE; a new `start` with `num_kernels`=0 -> no `bram_en` and `all_done` one cycle later.
